// File: rtl/crtc_regs.sv
// 6545/6845-style CRTC register file: CPU-writable timing registers, cursor and light-pen registers.
// Optional CRTC_VSYNC_LATCH_EN adds vsync_i and shadows the timing outputs until the next vertical sync.
module crtc_regs #(
  parameter int unsigned NUM_REGS = 18,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cs_i,
  input  logic              rs_i,
  input  logic              rw_i,
  input  logic              strobe_i,
  input  logic [7:0]        data_i,
  output logic [7:0]        data_o,
  input  logic              lpen_i,
  input  logic [13:0]       ma_i,
`ifdef CRTC_VSYNC_LATCH_EN
  input  logic              vsync_i,
`endif
  output logic [7:0]        h_total_o,
  output logic [7:0]        h_displayed_o,
  output logic [7:0]        h_sync_pos_o,
  output logic [7:0]        sync_width_o,
  output logic [6:0]        v_total_o,
  output logic [4:0]        v_adjust_o,
  output logic [6:0]        v_displayed_o,
  output logic [6:0]        v_sync_pos_o,
  output logic [4:0]        scan_line_o,
  output logic [6:0]        cursor_start_o,
  output logic [4:0]        cursor_end_o,
  output logic [13:0]       display_start_o,
  output logic [13:0]       cursor_addr_o
);

  typedef enum logic {LP_ARMED, LP_HELD} lp_state_t;

  logic [7:0]        regs [NUM_REGS];
  logic [7:0]        tim  [14];
  logic [ADDR_W-1:0] addr;
  logic [1:0]        lp_sync;
  logic              lp_prev;
  logic              lp_rise;
  logic              lp_rearm;
  logic              lp_capture;
  lp_state_t         lp_state, lp_next;
  logic              acc, wr_addr, wr_data, rd_any, rd_data;
  logic [7:0]        rd_val;

  function automatic logic [7:0] wr_mask(input logic [ADDR_W-1:0] a);
    case (int'(a))
      0, 1, 2, 3, 13, 15: wr_mask = 8'hFF;
      4, 6, 7, 10:        wr_mask = 8'h7F;
      5, 9, 11:           wr_mask = 8'h1F;
      8:                  wr_mask = 8'h03;
      12, 14:             wr_mask = 8'h3F;
      default:            wr_mask = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] reset_val(input int unsigned i);
    case (i)
      0:       reset_val = 8'd63;
      1:       reset_val = 8'd40;
      2:       reset_val = 8'd48;
      3:       reset_val = 8'h15;
      4:       reset_val = 8'd32;
      6:       reset_val = 8'd25;
      7:       reset_val = 8'd28;
      9:       reset_val = 8'd7;
      12:      reset_val = 8'h10;
      default: reset_val = 8'h00;
    endcase
  endfunction

  assign acc      = cs_i & strobe_i;
  assign wr_addr  = acc & ~rw_i & ~rs_i;
  assign wr_data  = acc & ~rw_i & rs_i;
  assign rd_any   = acc & rw_i;
  assign rd_data  = acc & rw_i & rs_i;
  assign lp_rise  = lp_sync[1] & ~lp_prev;
  assign lp_rearm = rd_data & ((addr == ADDR_W'(16)) | (addr == ADDR_W'(17)));

  always_comb begin
    rd_val = 8'h00;
    case (int'(addr))
      14:      rd_val = regs[14];
      15:      rd_val = regs[15];
      16:      rd_val = regs[16];
      17:      rd_val = regs[17];
      default: rd_val = 8'h00;
    endcase
  end

  // Armed capture has priority over a same-cycle re-arm read.
  always_comb begin
    lp_next    = lp_state;
    lp_capture = 1'b0;
    case (lp_state)
      LP_ARMED: begin
        if (lp_rise) begin
          lp_capture = 1'b1;
          lp_next    = LP_HELD;
        end
      end
      LP_HELD: begin
        if (lp_rearm) lp_next = LP_ARMED;
      end
      default: lp_next = LP_ARMED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reset_val(i);
      addr     <= '0;
      data_o   <= '0;
      lp_sync  <= '0;
      lp_prev  <= 1'b0;
      lp_state <= LP_ARMED;
    end else begin
      lp_sync  <= {lp_sync[0], lpen_i};
      lp_prev  <= lp_sync[1];
      lp_state <= lp_next;
      if (wr_addr) addr <= data_i[ADDR_W-1:0];
      if (wr_data && (addr < ADDR_W'(16))) regs[addr] <= data_i & wr_mask(addr);
      if (rd_any) data_o <= rd_data ? rd_val : 8'h00;
      if (lp_capture) begin
        regs[16] <= {2'b00, ma_i[13:8]};
        regs[17] <= ma_i[7:0];
      end
    end
  end

`ifdef CRTC_VSYNC_LATCH_EN
  logic [7:0] shadow [14];
  logic       vsync_d;
  logic       load_pend;

  // Shadow reloads one cycle after the vsync rise; a write in that same cycle waits for the next frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 14; i++) shadow[i] <= reset_val(i);
      vsync_d   <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      vsync_d   <= vsync_i;
      load_pend <= vsync_i & ~vsync_d;
      if (load_pend) begin
        for (int unsigned i = 0; i < 14; i++) shadow[i] <= regs[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 14; i++) tim[i] = shadow[i];
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < 14; i++) tim[i] = regs[i];
  end
`endif

  assign h_total_o       = tim[0];
  assign h_displayed_o   = tim[1];
  assign h_sync_pos_o    = tim[2];
  assign sync_width_o    = tim[3];
  assign v_total_o       = tim[4][6:0];
  assign v_adjust_o      = tim[5][4:0];
  assign v_displayed_o   = tim[6][6:0];
  assign v_sync_pos_o    = tim[7][6:0];
  assign scan_line_o     = tim[9][4:0];
  assign display_start_o = {tim[12][5:0], tim[13]};
  assign cursor_start_o  = regs[10][6:0];
  assign cursor_end_o    = regs[11][4:0];
  assign cursor_addr_o   = {regs[14][5:0], regs[15]};

endmodule

// File: tb/tb_crtc_regs.sv
// Randomized self-checking bench for crtc_regs against a behavioural register-file model.
module tb_crtc_regs;

  logic        clk = 1'b0;
  logic        reset, cs, rs, rw, strobe, lpen, vsync;
  logic [7:0]  data_i;
  logic [13:0] ma;
  logic [7:0]  data_o, h_total, h_displayed, h_sync_pos, sync_width;
  logic [6:0]  v_total, v_displayed, v_sync_pos, cursor_start;
  logic [4:0]  v_adjust, scan_line, cursor_end;
  logic [13:0] display_start, cursor_addr;

  crtc_regs #(.NUM_REGS(18), .ADDR_W(5)) dut (
    .clk_i(clk), .reset_i(reset), .cs_i(cs), .rs_i(rs), .rw_i(rw), .strobe_i(strobe),
    .data_i(data_i), .data_o(data_o), .lpen_i(lpen), .ma_i(ma),
`ifdef CRTC_VSYNC_LATCH_EN
    .vsync_i(vsync),
`endif
    .h_total_o(h_total), .h_displayed_o(h_displayed), .h_sync_pos_o(h_sync_pos),
    .sync_width_o(sync_width), .v_total_o(v_total), .v_adjust_o(v_adjust),
    .v_displayed_o(v_displayed), .v_sync_pos_o(v_sync_pos), .scan_line_o(scan_line),
    .cursor_start_o(cursor_start), .cursor_end_o(cursor_end),
    .display_start_o(display_start), .cursor_addr_o(cursor_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: register contents, pointer, read latch, light-pen history.
  logic [7:0] m_reg [18];
  logic [7:0] m_sh  [14];
  int         m_addr;
  logic [7:0] m_do;
  bit         m_armed;
  bit         lp_h [3];
  bit         m_vs_prev, m_load;

  function automatic logic [7:0] mask_of(input int a);
    if (a <= 3 || a == 13 || a == 15) return 8'hFF;
    if (a == 4 || a == 6 || a == 7 || a == 10) return 8'h7F;
    if (a == 5 || a == 9 || a == 11) return 8'h1F;
    if (a == 8) return 8'h03;
    if (a == 12 || a == 14) return 8'h3F;
    return 8'h00;
  endfunction

  function automatic logic [7:0] def_of(input int a);
    case (a)
      0: return 63;  1: return 40;  2: return 48;  3: return 8'h15;
      4: return 32;  6: return 25;  7: return 28;  9: return 7;
      12: return 8'h10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] tv(input int i);
`ifdef CRTC_VSYNC_LATCH_EN
    return m_sh[i];
`else
    return m_reg[i];
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 18; i++) m_reg[i] = def_of(i);
      for (int i = 0; i < 14; i++) m_sh[i] = def_of(i);
      m_addr = 0; m_do = 0; m_armed = 1;
      lp_h[0] = 0; lp_h[1] = 0; lp_h[2] = 0;
      m_vs_prev = 0; m_load = 0;
    end else begin
      bit acc, rise, rearm;
      acc   = cs && strobe;
      rise  = lp_h[1] && !lp_h[2];
      rearm = acc && rw && rs && (m_addr == 16 || m_addr == 17);
      if (m_load) for (int i = 0; i < 14; i++) m_sh[i] = m_reg[i];
      m_load    = vsync && !m_vs_prev;
      m_vs_prev = vsync;
      if (acc && rw) m_do = (rs && m_addr >= 14 && m_addr <= 17) ? m_reg[m_addr] : 8'h00;
      if (acc && !rw && rs && m_addr < 16) m_reg[m_addr] = data_i & mask_of(m_addr);
      if (acc && !rw && !rs) m_addr = int'(data_i[4:0]);
      if (rise && m_armed) begin
        m_reg[16] = {2'b00, ma[13:8]};
        m_reg[17] = ma[7:0];
        m_armed   = 0;
      end else if (rearm) m_armed = 1;
      lp_h[2] = lp_h[1]; lp_h[1] = lp_h[0]; lp_h[0] = lpen;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_o",        data_o,        m_do);
      check("h_total",       h_total,       tv(0));
      check("h_displayed",   h_displayed,   tv(1));
      check("h_sync_pos",    h_sync_pos,    tv(2));
      check("sync_width",    sync_width,    tv(3));
      check("v_total",       v_total,       tv(4));
      check("v_adjust",      v_adjust,      tv(5));
      check("v_displayed",   v_displayed,   tv(6));
      check("v_sync_pos",    v_sync_pos,    tv(7));
      check("scan_line",     scan_line,     tv(9));
      check("display_start", display_start, {tv(12), tv(13)} & 16'h3FFF);
      check("cursor_start",  cursor_start,  m_reg[10]);
      check("cursor_end",    cursor_end,    m_reg[11]);
      check("cursor_addr",   cursor_addr,   {m_reg[14], m_reg[15]} & 16'h3FFF);
    end
  end

  task automatic bus(input logic rw_v, input logic rs_v, input logic [7:0] d);
    cs = 1; strobe = 1; rw = rw_v; rs = rs_v; data_i = d;
    @(negedge clk);
    cs = 0; strobe = 0;
  endtask

  task automatic lp_pulse();
    lpen = 1; repeat (4) @(negedge clk);
    lpen = 0; repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1; cs = 0; rs = 0; rw = 0; strobe = 0; lpen = 0; vsync = 0;
    data_i = 0; ma = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk_en = 1;
    check("rst_h_total", h_total, 63);
    check("rst_h_displayed", h_displayed, 40);
    check("rst_v_total", v_total, 32);
    check("rst_display_start", display_start, 14'h1000);
    check("rst_data_o", data_o, 0);

`ifdef CRTC_VSYNC_LATCH_EN
    bus(0, 0, 1); bus(0, 1, 8'h50);
    bus(0, 0, 4); bus(0, 1, 8'hFF);
    check("vs_hold_h_displayed", h_displayed, 40);
    check("vs_hold_v_total", v_total, 32);
    vsync = 1; @(negedge clk);
    check("vs_edge_h_displayed", h_displayed, 40);
    @(negedge clk);
    check("vs_load_h_displayed", h_displayed, 8'h50);
    check("vs_load_v_total", v_total, 7'h7F);
    vsync = 0;
`else
    bus(0, 0, 1); bus(0, 1, 8'h50);
    check("wr_h_displayed", h_displayed, 8'h50);
    bus(0, 0, 4); bus(0, 1, 8'hFF);
    check("wr_v_total_masked", v_total, 7'h7F);
`endif

    bus(0, 0, 14); bus(0, 1, 8'hFF);
    bus(0, 0, 15); bus(0, 1, 8'h34);
    check("cursor_addr", cursor_addr, 14'h3F34);
    bus(0, 0, 14); bus(1, 1, 0);
    check("rd_r14", data_o, 8'h3F);
    bus(0, 0, 0); bus(1, 1, 0);
    check("rd_r0_wo", data_o, 8'h00);

    ma = 14'h0123; lp_pulse();
    ma = 14'h0456; lp_pulse();
    bus(0, 0, 16); bus(1, 1, 0);
    check("lp_r16_first", data_o, 8'h01);
    bus(0, 0, 17); bus(1, 1, 0);
    check("lp_r17_first", data_o, 8'h23);
    lp_pulse();
    bus(1, 1, 0);
    check("lp_r17_rearm", data_o, 8'h56);
    bus(0, 0, 16); bus(1, 1, 0);
    check("lp_r16_rearm", data_o, 8'h04);

    bus(0, 0, 20); bus(0, 1, 8'hAA);
    bus(0, 0, 16); bus(0, 1, 8'h55);
    bus(1, 1, 0);
    check("ro_r16_kept", data_o, 8'h04);
    check("ro_h_total_kept", h_total, 63);

    bus(0, 0, 0);
    reset = 1; cs = 1; strobe = 1; rw = 0; rs = 1; data_i = 8'h11;
    @(negedge clk);
    reset = 0; cs = 0; strobe = 0;
    check("midrst_h_total", h_total, 63);
    check("midrst_data_o", data_o, 0);

    for (int n = 0; n < 3000; n++) begin
      cs     = ($urandom % 4) != 0;
      strobe = $urandom % 2;
      rw     = $urandom % 2;
      rs     = $urandom % 2;
      data_i = (!rw && !rs) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      if ($urandom % 8 == 0) lpen = ~lpen;
      if ($urandom % 10 == 0) vsync = ~vsync;
      ma     = 14'($urandom);
      reset  = ($urandom % 250) == 0;
      @(negedge clk);
    end
    reset = 0; cs = 0; strobe = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
